// File: rtl/frame_builder_pkg.sv
// Shared frame protocol definitions: SOF byte, status codes, cmd bit-fields, FSM states.
// Used by both the response frame builder and the frame parser.
package frame_builder_pkg;

    localparam logic [7:0] SOF_DEVICE_TO_HOST = 8'h5A;

    localparam logic [7:0] STATUS_OK         = 8'h00;
    localparam logic [7:0] STATUS_CRC_ERR    = 8'h01;
    localparam logic [7:0] STATUS_CMD_INV    = 8'h02;
    localparam logic [7:0] STATUS_ADDR_ALIGN = 8'h03;
    localparam logic [7:0] STATUS_TIMEOUT    = 8'h04;
    localparam logic [7:0] STATUS_LEN_RANGE  = 8'h07;

    localparam int CMD_READ_BIT = 7;
    localparam int CMD_SIZE_LSB = 4;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        STATUS,
        CMD,
        DATA,
        CRC,
        DONE
    } frame_state_t;

    // Payload bytes carried by a response: only successful reads return data.
    function automatic logic [2:0] data_len(input logic [7:0] status, input logic [7:0] cmd);
        logic [2:0] n;
        n = 3'd0;
        if (cmd[CMD_READ_BIT] && status == STATUS_OK) begin
            case (cmd[CMD_SIZE_LSB +: 2])
                2'b00:   n = 3'd1;
                2'b01:   n = 3'd2;
                2'b10:   n = 3'd4;
                default: n = 3'd0;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/frame_builder_if.sv
// Request / TX FIFO bundle between a requester and the frame builder.
// master drives the request and FIFO status; slave is the builder.
interface frame_builder_if;
    logic        build_req;
    logic [7:0]  status_code;
    logic [7:0]  cmd_echo;
    logic [31:0] read_data;
    logic        tx_fifo_full;
    logic        tx_fifo_wr_en;
    logic [7:0]  tx_fifo_data;
    logic        busy;
    logic        frame_done;

    modport master (
        output build_req, status_code, cmd_echo, read_data, tx_fifo_full,
        input  tx_fifo_wr_en, tx_fifo_data, busy, frame_done
    );

    modport slave (
        input  build_req, status_code, cmd_echo, read_data, tx_fifo_full,
        output tx_fifo_wr_en, tx_fifo_data, busy, frame_done
    );
endinterface

// File: rtl/frame_builder_crc8_update.sv
// One-byte CRC-8 step (MSB first, no reflection); purely combinational.
// Latency 0; no flow control.
module crc8_update #(
    parameter logic [7:0] CRC_POLY = 8'h07
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);
    logic [7:0] c;

    always_comb begin
        c = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_out = c;
    end
endmodule

// File: rtl/frame_builder.sv
// Builds a response frame SOF/STATUS/CMD/data/CRC8 into a byte TX FIFO.
// Latency 1 cycle from accept to SOF; stalls on tx_fifo_full holding the current byte.
module frame_builder #(
    parameter logic [7:0] SOF_DEVICE_TO_HOST = frame_builder_pkg::SOF_DEVICE_TO_HOST,
    parameter logic [7:0] CRC_POLY           = 8'h07
) (
    input  logic           clk,
    input  logic           rst_n,
    frame_builder_if.slave bus
);
    import frame_builder_pkg::*;

    frame_state_t state;
    logic [7:0]   status_q;
    logic [7:0]   cmd_q;
    logic [31:0]  data_q;
    logic [7:0]   crc_q;
    logic [2:0]   cnt_q;
    logic         busy_q;
    logic         done_q;

    logic [2:0]   n_data;
    logic         emit;
    logic         wr;
    logic [7:0]   cur_byte;
    logic [7:0]   data_byte;
    logic [7:0]   crc_next;

    assign n_data = data_len(status_q, cmd_q);
    assign emit   = (state == SOF) || (state == STATUS) || (state == CMD) ||
                    (state == DATA) || (state == CRC);
    // Write strobe must see tx_fifo_full in the same cycle, so it is a decode, not a flop.
    assign wr     = emit && !bus.tx_fifo_full;

    always_comb begin
        case (cnt_q[1:0])
            2'd0:    data_byte = data_q[7:0];
            2'd1:    data_byte = data_q[15:8];
            2'd2:    data_byte = data_q[23:16];
            default: data_byte = data_q[31:24];
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        case (state)
            SOF:     cur_byte = SOF_DEVICE_TO_HOST;
            STATUS:  cur_byte = status_q;
            CMD:     cur_byte = cmd_q;
            DATA:    cur_byte = data_byte;
            CRC:     cur_byte = crc_q;
            default: cur_byte = 8'h00;
        endcase
    end

    crc8_update #(.CRC_POLY(CRC_POLY)) u_crc (
        .crc_in  (crc_q),
        .byte_in (cur_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            status_q <= 8'h00;
            cmd_q    <= 8'h00;
            data_q   <= 32'h0;
            crc_q    <= 8'h00;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.build_req) begin
                        status_q <= bus.status_code;
                        cmd_q    <= bus.cmd_echo;
                        data_q   <= bus.read_data;
                        crc_q    <= 8'h00;
                        cnt_q    <= 3'd0;
                        busy_q   <= 1'b1;
                        state    <= SOF;
                    end
                end
                SOF: begin
                    if (wr) state <= STATUS;
                end
                STATUS: begin
                    if (wr) begin
                        crc_q <= crc_next;
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (wr) begin
                        crc_q <= crc_next;
                        state <= (n_data == 3'd0) ? CRC : DATA;
                    end
                end
                DATA: begin
                    if (wr) begin
                        crc_q <= crc_next;
                        if (cnt_q == n_data - 3'd1) state <= CRC;
                        else                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                CRC: begin
                    if (wr) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_fifo_wr_en = wr;
    assign bus.tx_fifo_data  = wr ? cur_byte : 8'h00;
    assign bus.busy          = busy_q;
    assign bus.frame_done    = done_q;
endmodule

// File: tb/tb_frame_builder.sv
// Self-checking bench for frame_builder: directed protocol cases plus random frames
// with random FIFO backpressure, checked against a byte-list reference model.
module tb_frame_builder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_builder_if bus();

    frame_builder #(.SOF_DEVICE_TO_HOST(8'h5A), .CRC_POLY(8'h07)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int cyc, first_wr, done_cnt, done_cyc;
    logic s_busy, s_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC: textbook bit-serial division, one message bit at a time.
    function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
        logic [7:0] r;
        logic fb;
        r = 8'h00;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[i][b];
                r  = {r[6:0], 1'b0};
                if (fb) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction

    task automatic build_expected(input logic [7:0] st, input logic [7:0] cmd, input logic [31:0] rd);
        logic [7:0] body[$];
        int n;
        n = 0;
        if (cmd[7] && st == 8'h00) begin
            case (cmd[5:4])
                2'd0: n = 1;
                2'd1: n = 2;
                2'd2: n = 4;
                default: n = 0;
            endcase
        end
        body = {st, cmd};
        for (int i = 0; i < n; i++) body.push_back(8'((rd >> (8 * i)) & 32'hFF));
        exp_q = {8'h5A};
        foreach (body[i]) exp_q.push_back(body[i]);
        exp_q.push_back(ref_crc(body));
    endtask

    // Sample at the falling edge, then move to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        s_busy = bus.busy;
        s_done = bus.frame_done;
        if (bus.tx_fifo_wr_en) begin
            got_q.push_back(bus.tx_fifo_data);
            if (first_wr < 0) first_wr = cyc;
        end
        if (bus.tx_fifo_full) chk("no_wr_when_full", 32'(bus.tx_fifo_wr_en), 32'h0);
        else if (!bus.tx_fifo_wr_en) chk("idle_data_zero", 32'(bus.tx_fifo_data), 32'h0);
        if (bus.frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // bp_mode: 0 none, 1 random full, 2 full for 5 cycles over the CMD slot.
    task automatic do_frame(input logic [7:0] st, input logic [7:0] cmd, input logic [31:0] rd,
                            input int bp_mode, input int rereq_at);
        build_expected(st, cmd, rd);
        got_q.delete();
        first_wr = -1; done_cnt = 0; done_cyc = -1; cyc = 0;
        bus.build_req = 1'b1; bus.status_code = st; bus.cmd_echo = cmd; bus.read_data = rd;
        bus.tx_fifo_full = 1'b0;
        step();
        chk("busy_at_accept", 32'(s_busy), 32'h0);
        bus.build_req = 1'b0;
        bus.status_code = 8'($urandom); bus.cmd_echo = 8'($urandom); bus.read_data = $urandom;
        for (int k = 1; k <= 300 && done_cnt == 0; k++) begin
            case (bp_mode)
                1: bus.tx_fifo_full = ($urandom_range(0, 3) == 0);
                2: bus.tx_fifo_full = (k >= 3 && k <= 7);
                default: bus.tx_fifo_full = 1'b0;
            endcase
            bus.build_req = (k == rereq_at);
            step();
            chk("busy_in_frame", 32'(s_busy), 32'h1);
        end
        bus.build_req = 1'b0;
        bus.tx_fifo_full = 1'b0;
        chk("frame_done_seen", 32'(done_cnt), 32'h1);
        chk("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) chk($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        if (bp_mode == 0) begin
            chk("sof_latency", 32'(first_wr), 32'h1);
            chk("done_cycle", 32'(done_cyc), 32'(exp_q.size() + 1));
        end else if (bp_mode == 2) begin
            chk("done_cycle_bp", 32'(done_cyc), 32'(exp_q.size() + 6));
        end
        step();
        chk("busy_drop", 32'(s_busy), 32'h0);
        chk("done_pulse_width", 32'(s_done), 32'h0);
        if (rereq_at > 0) begin
            repeat (8) step();
            chk("no_second_frame", 32'(got_q.size()), 32'(exp_q.size()));
        end
    endtask

    logic [7:0] st_pick[8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h07};

    initial begin
        bus.build_req = 1'b0; bus.status_code = 8'h00; bus.cmd_echo = 8'h00;
        bus.read_data = 32'h0; bus.tx_fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(bus.tx_fifo_wr_en), 32'h0);
        chk("rst_data", 32'(bus.tx_fifo_data), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;
        first_wr = -1; done_cnt = 0; cyc = 0;
        step();

        do_frame(8'h00, 8'h20, 32'h0, 0, 0);
        chk("ack_crc_E0", 32'(got_q[3]), 32'hE0);
        do_frame(8'h00, 8'hA0, 32'h12345678, 0, 0);
        chk("rd32_lsb_first", 32'(got_q[3]), 32'h78);
        chk("rd32_msb_last", 32'(got_q[6]), 32'h12);
        do_frame(8'h01, 8'hA0, 32'h12345678, 0, 0);
        chk("err_crc_7C", 32'(got_q[3]), 32'h7C);
        do_frame(8'h00, 8'h90, 32'hDEADBEEF, 2, 0);
        do_frame(8'h00, 8'h20, 32'h0, 0, 2);
        do_frame(8'h00, 8'hB0, 32'hCAFEF00D, 0, 0);

        // Reset while the third data byte is on the bus.
        build_expected(8'h00, 8'hA0, 32'hA1B2C3D4);
        got_q.delete(); first_wr = -1; done_cnt = 0; cyc = 0;
        bus.build_req = 1'b1; bus.status_code = 8'h00; bus.cmd_echo = 8'hA0;
        bus.read_data = 32'hA1B2C3D4;
        step();
        bus.build_req = 1'b0;
        repeat (5) step();
        chk("pre_reset_wr_active", 32'(bus.tx_fifo_wr_en), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(bus.tx_fifo_wr_en), 32'h0);
        chk("midrst_data", 32'(bus.tx_fifo_data), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_done", 32'(bus.frame_done), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        repeat (3) step();
        chk("no_resume_after_reset", 32'(got_q.size()), 32'h0);
        do_frame(8'h00, 8'hA0, 32'hA1B2C3D4, 0, 0);

        for (int t = 0; t < 40; t++) begin
            do_frame(st_pick[$urandom_range(0, 7)], 8'($urandom), $urandom,
                     int'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
